spi_target: RTL

// - SPI mode-0 target (slave) receiver: the listening end of the spi_controller link.
// - Oversamples an external SCK/MOSI/CS_N/DC bundle in the system clock domain.
// - Assembles MSB-first bytes, each tagged with its DC bit, into a receive FIFO that the CPU drains over the memory bus.
// - Returns a CPU-loaded byte on MISO.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rx_fifo.sv | 48 ++++
 rtl/spi_target.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and register offsets
package spi_pkg;

  localparam logic [7:0] REG_RX_DATA = 8'h00;
  localparam logic [7:0] REG_TX_DATA = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h08;
  localparam logic [7:0] REG_COUNT   = 8'h0C;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {IDLE, ACTIVE} spi_tgt_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - synchronous receive FIFO of dc-tagged bytes
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  rx_entry_t              push_data,
  input  logic                   pop,
  output rx_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  rx_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target receiver with RX FIFO and bus registers
module spi_target
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  input  logic        spi_clk_in,
  input  logic        spi_mosi_in,
  input  logic        spi_cs_n_in,
  input  logic        spi_dc_in,
  output logic        spi_miso_out,
  output logic        irq_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sck_sr, mosi_sr, cs_sr, dc_sr, settle_sr;
  logic                   sck_prev;
  logic                   sck, mosi, cs_n, dc, settled;
  logic                   sck_rise, sck_fall;

  spi_tgt_state_t state;
  logic [2:0]     bit_cnt;
  logic [6:0]     rx_shift;
  logic [7:0]     tx_shift;
  logic [7:0]     tx_reg;
  logic           dc_lat;
  logic           armed;
  logic           frame_err;
  logic           overrun;

  logic [7:0]     offset;
  logic           bus_wr, status_wr, tx_wr;
  logic           rd_req, rd_req_prev, pop;
  logic           push, overrun_set;
  rx_entry_t      push_data, fifo_head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           unused_bits;

  assign unused_bits = &{1'b0, address_in[31:8], write_value_in[31:8], write_value_in[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sr    <= '0;
      mosi_sr   <= '0;
      cs_sr     <= '1;
      dc_sr     <= '0;
      settle_sr <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sr    <= {sck_sr[SYNC_STAGES-2:0], spi_clk_in};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi_in};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n_in};
      dc_sr     <= {dc_sr[SYNC_STAGES-2:0], spi_dc_in};
      settle_sr <= {settle_sr[SYNC_STAGES-2:0], 1'b1};
      sck_prev  <= sck;
    end
  end

  assign sck      = sck_sr[SYNC_STAGES-1];
  assign mosi     = mosi_sr[SYNC_STAGES-1];
  assign cs_n     = cs_sr[SYNC_STAGES-1];
  assign dc       = dc_sr[SYNC_STAGES-1];
  assign settled  = settle_sr[SYNC_STAGES-1];
  assign sck_rise = sck && !sck_prev;
  assign sck_fall = !sck && sck_prev;

  assign offset    = address_in[7:0];
  assign bus_wr    = sel_in && (|write_mask_in);
  assign status_wr = bus_wr && (offset == REG_STATUS);
  assign tx_wr     = bus_wr && (offset == REG_TX_DATA);
  assign rd_req    = sel_in && read_in && (offset == REG_RX_DATA);
  assign pop       = rd_req && !rd_req_prev;
  assign ready_out = sel_in;

  assign push        = (state == ACTIVE) && !cs_n && sck_rise && (bit_cnt == 3'd7);
  assign push_data   = {dc_lat, rx_shift, mosi};
  assign overrun_set = push && fifo_full && !pop;
  assign irq_out     = !fifo_empty || overrun;

  // A frame is only accepted after CS_N has been seen high once the synchronizers
  // carry real samples, so a frame cut by reset is ignored until it restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      dc_lat       <= 1'b0;
      armed        <= 1'b0;
      frame_err    <= 1'b0;
      spi_miso_out <= 1'b0;
    end else begin
      if (settled && cs_n) armed <= 1'b1;
      if (status_wr && write_value_in[4]) frame_err <= 1'b0;
      spi_miso_out <= (state == ACTIVE) ? tx_shift[7] : 1'b0;
      case (state)
        IDLE: begin
          if (armed && !cs_n) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            tx_shift <= tx_reg;
          end
        end
        ACTIVE: begin
          if (cs_n) begin
            if (bit_cnt != 3'd0) frame_err <= 1'b1;
            state <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[5:0], mosi};
            if (bit_cnt == 3'd0) dc_lat <= dc;
            if (bit_cnt == 3'd7) begin
              bit_cnt  <= '0;
              tx_shift <= tx_reg;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          // No shift at a byte boundary: the freshly loaded MSB must reach the next rise.
          end else if (sck_fall && bit_cnt != 3'd0) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      tx_reg      <= 8'h00;
      rd_req_prev <= 1'b0;
    end else begin
      rd_req_prev <= rd_req;
      if (tx_wr) tx_reg <= write_value_in[7:0];
      if (status_wr && write_value_in[3]) overrun <= 1'b0;
      if (overrun_set) overrun <= 1'b1;
    end
  end

  always_comb begin
    read_value_out = '0;
    if (sel_in && read_in) begin
      case (offset)
        REG_RX_DATA: if (!fifo_empty) read_value_out = {23'b0, fifo_head};
        REG_STATUS:  read_value_out = {27'b0, frame_err, overrun, (state == ACTIVE),
                                       fifo_full, fifo_empty};
        REG_COUNT:   read_value_out = {{(32-CW){1'b0}}, fifo_count};
        default:     read_value_out = '0;
      endcase
    end
  end

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
